// File: rtl/line_pkg.sv
// Shared types and helpers for the Bresenham line rasteriser.
package line_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Signed working width for dx/dy/err: 2*err must stay representable.
    function automatic int ew(input int xw, input int yw);
        return ((xw > yw) ? xw : yw) + 2;
    endfunction

    localparam int PIX_XW = 11;
    localparam int PIX_YW = 10;
    localparam int PIX_CW = 24;

    typedef struct packed {
        logic [PIX_XW-1:0] x;
        logic [PIX_YW-1:0] y;
        logic [PIX_CW-1:0] color;
        logic              on;
        logic              last;
    } pixel_t;

endpackage

// File: rtl/line_raster_gen_bres_step.sv
// One combinational Bresenham step: advances x and/or y and updates the error term.
module bres_step #(
    parameter int XW = 11,
    parameter int YW = 10,
    parameter int EW = 13
) (
    input  logic [XW-1:0]        cur_x_i,
    input  logic [YW-1:0]        cur_y_i,
    input  logic signed [EW-1:0] err_i,
    input  logic signed [EW-1:0] dx_i,
    input  logic signed [EW-1:0] dy_i,
    input  logic                 sx_i,
    input  logic                 sy_i,
    output logic [XW-1:0]        nxt_x_o,
    output logic [YW-1:0]        nxt_y_o,
    output logic signed [EW-1:0] nxt_err_o
);

    logic signed [EW-1:0] e2;

    // sx_i/sy_i set means the axis steps in the negative direction.
    always_comb begin
        e2        = err_i <<< 1;
        nxt_x_o   = cur_x_i;
        nxt_y_o   = cur_y_i;
        nxt_err_o = err_i;
        if (e2 >= dy_i) begin
            nxt_err_o = nxt_err_o + dy_i;
            nxt_x_o   = sx_i ? (cur_x_i - XW'(1)) : (cur_x_i + XW'(1));
        end
        if (e2 <= dx_i) begin
            nxt_err_o = nxt_err_o + dx_i;
            nxt_y_o   = sy_i ? (cur_y_i - YW'(1)) : (cur_y_i + YW'(1));
        end
    end

endmodule

// File: rtl/line_raster_gen.sv
// Bresenham line rasteriser: takes one line command, streams one pixel per cycle
// with valid/ready back-pressure, dash masking, abort and a done pulse.
module line_raster_gen
    import line_pkg::*;
#(
    parameter int XW = 11,
    parameter int YW = 10,
    parameter int CW = 24,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x0,
    input  logic [XW-1:0] cmd_x1,
    input  logic [YW-1:0] cmd_y0,
    input  logic [YW-1:0] cmd_y1,
    input  logic [CW-1:0] cmd_color,
    input  logic [PW-1:0] cmd_pattern,
    input  logic          abort,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [CW-1:0] pix_color,
    output logic          pix_on,
    output logic          pix_last,
    output logic          busy,
    output logic          done
);

    localparam int EW = ew(XW, YW);
    localparam int IW = (PW > 1) ? $clog2(PW) : 1;

    state_t               state_q, state_d;
    logic [XW-1:0]        cur_x_q, cur_x_d, end_x_q, end_x_d;
    logic [YW-1:0]        cur_y_q, cur_y_d, end_y_q, end_y_d;
    logic                 sx_q, sx_d, sy_q, sy_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        color_q, color_d;
    logic [PW-1:0]        pattern_q, pattern_d;

    logic [XW-1:0]        step_x, adx;
    logic [YW-1:0]        step_y, ady;
    logic signed [EW-1:0] step_err;
    logic                 run, at_end;

    bres_step #(.XW(XW), .YW(YW), .EW(EW)) u_step (
        .cur_x_i  (cur_x_q),
        .cur_y_i  (cur_y_q),
        .err_i    (err_q),
        .dx_i     (dx_q),
        .dy_i     (dy_q),
        .sx_i     (sx_q),
        .sy_i     (sy_q),
        .nxt_x_o  (step_x),
        .nxt_y_o  (step_y),
        .nxt_err_o(step_err)
    );

    assign run       = (state_q == RUN);
    assign at_end    = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
    assign cmd_ready = (state_q == IDLE) && !reset;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN) && !abort;
    assign pix_valid = run;
    assign pix_x     = cur_x_q;
    assign pix_y     = cur_y_q;
    assign pix_color = color_q;
    assign pix_on    = run && pattern_q[idx_q];
    assign pix_last  = run && at_end;

    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        end_x_d   = end_x_q;
        end_y_d   = end_y_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        err_d     = err_q;
        idx_d     = idx_q;
        color_d   = color_q;
        pattern_d = pattern_q;
        adx       = '0;
        ady       = '0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    sx_d      = (cmd_x1 < cmd_x0);
                    sy_d      = (cmd_y1 < cmd_y0);
                    adx       = sx_d ? (cmd_x0 - cmd_x1) : (cmd_x1 - cmd_x0);
                    ady       = sy_d ? (cmd_y0 - cmd_y1) : (cmd_y1 - cmd_y0);
                    dx_d      = $signed({{(EW-XW){1'b0}}, adx});
                    dy_d      = -$signed({{(EW-YW){1'b0}}, ady});
                    err_d     = dx_d + dy_d;
                    cur_x_d   = cmd_x0;
                    cur_y_d   = cmd_y0;
                    end_x_d   = cmd_x1;
                    end_y_d   = cmd_y1;
                    color_d   = cmd_color;
                    pattern_d = cmd_pattern;
                    idx_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Abort wins over a coincident pixel handshake.
                if (abort) begin
                    state_d = IDLE;
                end else if (pix_ready) begin
                    if (at_end) begin
                        state_d = FIN;
                    end else begin
                        cur_x_d = step_x;
                        cur_y_d = step_y;
                        err_d   = step_err;
                        idx_d   = (idx_q == IW'(PW-1)) ? '0 : (idx_q + IW'(1));
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            end_x_q   <= '0;
            end_y_q   <= '0;
            sx_q      <= 1'b0;
            sy_q      <= 1'b0;
            dx_q      <= '0;
            dy_q      <= '0;
            err_q     <= '0;
            idx_q     <= '0;
            color_q   <= '0;
            pattern_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            end_x_q   <= end_x_d;
            end_y_q   <= end_y_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            color_q   <= color_d;
            pattern_q <= pattern_d;
        end
    end

endmodule

// File: tb/tb_line_raster_gen.sv
// Directed bench for line_raster_gen: hand-counted lines checked pixel by pixel against a Bresenham reference.
module tb_line_raster_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_x0, cmd_x1;
    logic [9:0]  cmd_y0, cmd_y1;
    logic [23:0] cmd_color;
    logic [15:0] cmd_pattern;
    logic        abort;
    logic        pix_valid;
    logic        pix_ready;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_color;
    logic        pix_on;
    logic        pix_last;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    int qx[$];
    int qy[$];
    int qon[$];
    int qlast[$];

    line_raster_gen dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_x1     (cmd_x1),
        .cmd_y0     (cmd_y0),
        .cmd_y1     (cmd_y1),
        .cmd_color  (cmd_color),
        .cmd_pattern(cmd_pattern),
        .abort      (abort),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_color  (pix_color),
        .pix_on     (pix_on),
        .pix_last   (pix_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Textbook Bresenham, used as the reference pixel sequence.
    task automatic gen_ref(input int x0, input int y0, input int x1, input int y1,
                           input logic [15:0] pat);
        int x, y, dx, dy, sx, sy, err, e2, k;
        qx.delete(); qy.delete(); qon.delete(); qlast.delete();
        x = x0; y = y0;
        dx = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        dy = -((y1 >= y0) ? (y1 - y0) : (y0 - y1));
        sx = (x1 >= x0) ? 1 : -1;
        sy = (y1 >= y0) ? 1 : -1;
        err = dx + dy;
        k = 0;
        while (k < 4000) begin
            qx.push_back(x);
            qy.push_back(y);
            qon.push_back(int'(pat[k % 16]));
            qlast.push_back((x == x1 && y == y1) ? 1 : 0);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
            k++;
        end
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input logic [15:0] pat, input logic [23:0] col);
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_x0 = 11'(x0); cmd_y0 = 10'(y0);
        cmd_x1 = 11'(x1); cmd_y1 = 10'(y1);
        cmd_pattern = pat; cmd_color = col;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_line(input string name, input int x0, input int y0, input int x1, input int y1,
                            input logic [15:0] pat, input logic [23:0] col, input bit stall,
                            input int exp_n, input int exp_busy);
        int i, n, cyc, busy_cnt;
        bit held, rdy;
        logic [10:0] hx;
        logic [9:0]  hy;
        logic [23:0] hc;
        gen_ref(x0, y0, x1, y1, pat);
        n = qx.size();
        i = 0; cyc = 0; busy_cnt = 0; held = 0;
        pix_ready = 1'b1;
        send_cmd(x0, y0, x1, y1, pat, col);
        while (i < n && cyc < 6000) begin
            if (busy) busy_cnt++;
            check({name, "_pix_valid"}, pix_valid, 1);
            if (pix_valid) begin
                if (held) begin
                    check({name, "_hold_x"}, pix_x, hx);
                    check({name, "_hold_y"}, pix_y, hy);
                    check({name, "_hold_color"}, pix_color, hc);
                end
                check({name, "_x"}, pix_x, qx[i]);
                check({name, "_y"}, pix_y, qy[i]);
                check({name, "_on"}, pix_on, qon[i]);
                check({name, "_last"}, pix_last, qlast[i]);
                check({name, "_color"}, pix_color, col);
                rdy = stall ? bit'($urandom_range(0, 1)) : 1'b1;
                pix_ready = rdy;
                held = !rdy;
                hx = pix_x; hy = pix_y; hc = pix_color;
                if (rdy) i++;
            end
            @(negedge clk);
            cyc++;
        end
        check({name, "_pixel_count"}, i, exp_n);
        if (busy) busy_cnt++;
        check({name, "_done_pulse"}, done, 1);
        check({name, "_fin_valid"}, pix_valid, 0);
        pix_ready = 1'b1;
        @(negedge clk);
        check({name, "_done_clear"}, done, 0);
        check({name, "_idle_ready"}, cmd_ready, 1);
        check({name, "_idle_busy"}, busy, 0);
        if (exp_busy >= 0) check({name, "_busy_cycles"}, busy_cnt, exp_busy);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; pix_ready = 1'b0;
        cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0;
        cmd_color = '0; cmd_pattern = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);

        run_line("horiz", 10, 5, 14, 5, 16'hFFFF, 24'h123456, 1'b0, 5, 6);
        run_line("steep", 3, 9, 1, 2, 16'hFFFF, 24'h00FF00, 1'b0, 8, 9);
        run_line("oct0", 400, 240, 450, 260, 16'hA5A5, 24'h000001, 1'b0, 51, 52);
        run_line("oct1", 400, 240, 420, 290, 16'hA5A5, 24'h000002, 1'b0, 51, 52);
        run_line("oct2", 400, 240, 380, 290, 16'hA5A5, 24'h000003, 1'b0, 51, 52);
        run_line("oct3", 400, 240, 350, 260, 16'hA5A5, 24'h000004, 1'b0, 51, 52);
        run_line("oct4", 400, 240, 350, 220, 16'hA5A5, 24'h000005, 1'b0, 51, 52);
        run_line("oct5", 400, 240, 380, 190, 16'hA5A5, 24'h000006, 1'b0, 51, 52);
        run_line("oct6", 400, 240, 420, 190, 16'hA5A5, 24'h000007, 1'b0, 51, 52);
        run_line("oct7", 400, 240, 450, 220, 16'hA5A5, 24'h000008, 1'b0, 51, 52);
        run_line("long", 0, 0, 799, 479, 16'hFFFF, 24'hABCDEF, 1'b0, 800, 801);
        run_line("long_stall", 0, 0, 799, 479, 16'hFFFF, 24'hABCDEF, 1'b1, 800, -1);
        run_line("dash", 0, 0, 31, 0, 16'h00FF, 24'h0F0F0F, 1'b0, 32, 33);
        run_line("degen", 7, 7, 7, 7, 16'hFFFF, 24'hFFFFFF, 1'b0, 1, 2);

        // Abort on the fourth pixel, handshake in the same cycle ignored.
        pix_ready = 1'b1;
        send_cmd(0, 0, 20, 0, 16'hFFFF, 24'h111111);
        for (int k = 0; k < 3; k++) begin
            check("abort_pre_x", pix_x, k);
            @(negedge clk);
        end
        check("abort_at_x", pix_x, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", pix_valid, 0);
        check("abort_done", done, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        @(negedge clk);
        check("abort_no_late_done", done, 0);
        run_line("after_abort", 5, 1, 8, 1, 16'hFFFE, 24'h222222, 1'b0, 4, 5);

        // Abort while idle has no effect.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_ready", cmd_ready, 1);

        // Reset in the middle of a line.
        send_cmd(0, 0, 50, 0, 16'hFFFF, 24'hC0FFEE);
        repeat (4) @(negedge clk);
        check("midrst_running", pix_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", pix_valid, 0);
        check("midrst_x", pix_x, 0);
        check("midrst_y", pix_y, 0);
        check("midrst_color", pix_color, 0);
        check("midrst_on", pix_on, 0);
        check("midrst_last", pix_last, 0);
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_release_ready", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_raster_gen.md
# line_raster_gen

Parametrised Bresenham line rasteriser for the MTL display pipeline. It accepts one line command (two endpoints, colour, dash pattern) through a valid/ready handshake. It then streams one pixel per cycle through a back-pressurable valid/ready pixel port toward the frame-buffer writer. It handles all eight octants, degenerate lines, dashed lines and mid-line abort, and it does not depend on the raster scan counters.

## Interface
- XW, 11, x coordinate width (unsigned)
- YW, 10, y coordinate width (unsigned)
- CW, 24, colour width, passed through unchanged
- PW, 16, dash pattern length in bits
- clk  in  1  clock; everything is on the rising edge
- reset  in  1  reset, synchronous and active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE and not in reset)
- cmd_x0, cmd_x1  in  XW  endpoint x
- cmd_y0, cmd_y1  in  YW  endpoint y
- cmd_color  in  CW  line colour
- cmd_pattern  in  PW  dash mask; bit k applies to pixel index k mod PW
- abort  in  1  kill the current line
- pix_valid  out  1  pixel present
- pix_ready  in  1  consumer accepts the pixel
- pix_x  out  XW  pixel x
- pix_y  out  YW  pixel y
- pix_color  out  CW  latched colour
- pix_on  out  1  pattern bit for this pixel; consumer writes only when pix_on is 1
- pix_last  out  1  pixel is the endpoint (x1, y1)
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the last pixel transfers

## Operation
- States: IDLE, RUN, FIN.
- IDLE: cmd_ready=1. A transfer happens when cmd_valid&cmd_ready. On transfer, latch:
  - colour and pattern
  - cur=(x0,y0), end=(x1,y1)
  - sx=+1 if x1>=x0 else -1; sy=+1 if y1>=y0 else -1
  - dx=|x1-x0|, dy=-|y1-y0|, err=dx+dy, idx=0
  - then go to RUN.
- Arithmetic: dx, dy, err and e2 are signed, EW=max(XW,YW)+2 bits. Overflow cannot occur.
- RUN: pix_valid=1, pix_x/pix_y=cur, pix_on=pattern[idx], pix_last=(cur==end).
- On pix_valid&pix_ready, when not last, take one step using the pre-step err:
  - e2=2*err
  - if e2>=dy: err+=dy, x+=sx
  - if e2<=dx: err+=dx, y+=sy
  - both updates may apply in the same step (diagonal); the err increments add
  - idx=(idx+1) mod PW.
- On pix_valid&pix_ready with pix_last=1: go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Stall: pix_ready=0 holds every pixel output and all internal state stable. pix_valid must not drop while stalled.
- Pixel count per line is max(|x1-x0|,|y1-y0|)+1. Each coordinate changes by at most 1 per pixel. The sequence is identical for any stall pattern.
- Degenerate line (x0==x1 and y0==y1): one pixel, pix_last=1 on it.
- Abort in RUN or FIN: next state is IDLE, pix_valid=0, no done pulse. A handshake in the same cycle as abort is still counted by the consumer but is ignored by the block. Abort in IDLE has no effect.
- A command offered while busy waits; cmd_ready stays 0.

## Timing
- Reset values: state IDLE, pix_valid=0, pix_x=0, pix_y=0, pix_color=0, pix_on=0, pix_last=0, done=0, busy=0. cmd_ready=0 during reset and 1 in the first cycle after reset.
- Command accepted at edge N: first pixel valid in cycle N+1; busy=1 from cycle N+1.
- Throughput is 1 pixel/cycle with pix_ready held at 1.
- Last pixel transferred at edge M: done=1 in cycle M+1; cmd_ready=1 in cycle M+2.
- A line of P pixels with no stalls occupies exactly P+1 busy cycles.
- Reset in any state wins over abort and over both handshakes.

## Structure
- Package line_pkg holds:
  - state_t enum {IDLE, RUN, FIN}
  - function ew(XW,YW) returning max(XW,YW)+2
  - pixel struct typedef {x, y, color, on, last}.
- One purely combinational sub-module, bres_step. Inputs: cur x/y, err, dx, dy, sx, sy. Outputs: next x/y, next err.
- Top level holds the FSM, the registers and the pattern index.

## Test plan
- Horizontal line (10,5)->(14,5), pix_ready=1 → pixels x=10..14, y=5, pix_last on x=14; done pulses 1 cycle after; 6 busy cycles total.
- Steep reverse line (3,9)->(1,2) → 8 pixels from (3,9) to (1,2), y decreasing by 1 each pixel, x changing at most 1 per step. Checked against a reference Bresenham model; all 8 octants are swept from centre (400,240) with length 50.
- Random pix_ready (50%) on line (0,0)->(799,479) → 800 pixels identical to the unstalled run; outputs held stable whenever valid&!ready.
- Dash: cmd_pattern=16'h00FF, PW=16, line (0,0)->(31,0) → pix_on=1 for x 0..7 and 16..23, 0 otherwise.
- Degenerate (7,7)->(7,7) → single pixel with pix_last=1, done in the next cycle.
- Abort after 3 pixels of (0,0)->(20,0) → pix_valid=0 next cycle, no done, cmd_ready=1. A new command then runs cleanly from its own x0, with idx restarting at 0.
- Reset asserted mid-line → all outputs at their reset values in the next cycle.
